// File: rtl/mac_stream.sv
// mac_stream: streaming multiply-accumulate engine.
// Computes dot products of run-time length (1..MAX_LEN beats) over a
// valid/ready operand stream, in signed or unsigned mode, and presents each
// result with a sticky overflow flag on a valid/ready output port.
// Optional build macro: MAC_STREAM_SAT_EN -- when defined, the accumulator
// saturates to the mode's limit on overflow and stays clamped until the
// vector ends; when undefined, accumulation wraps modulo 2^ACC_W.
//
// Handshake: a beat moves on in_valid & in_ready & ena, a result moves on
// out_valid & out_ready & ena. Neither side may depend on the other's
// acceptance to raise valid; once out_valid is high, out_data/out_ovf hold
// until the result is taken. ena low freezes everything and drops in_ready.
module mac_stream #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              signed_mode,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   out_data_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic               mode_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic               out_ovf_q;
  logic               run_q;

  logic [LEN_W-1:0]        len_eff;
  logic                    in_fire;
  logic                    out_fire;
  logic                    start;
  logic                    last_beat;
  logic                    mode_sel;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]     prod_u;
  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W:0]          sum_w;
  logic                    s_ovf;
  logic                    u_ovf;
  logic                    add_ovf;
  logic                    ovf_next;
  logic [ACC_W-1:0]        acc_next;

  // run_q keeps in_ready low until the first enabled clock after reset.
  assign in_ready  = ena & run_q & ((state_q != HOLD) | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready & ena;
  // A beat accepted outside ACC always opens a new vector (IDLE, or HOLD
  // with the pending result leaving in the same cycle).
  assign start     = in_fire & (state_q != ACC);
  assign last_beat = ((cnt_q + LEN_W'(1)) == len_q);
  assign mode_sel  = (state_q == ACC) ? mode_q : signed_mode;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign dbg_state = state_q;

  // Effective length: 0 means one beat, anything above MAX_LEN is clamped.
  always_comb begin
    len_eff = len;
    if (len == '0)
      len_eff = LEN_W'(1);
    else if (len > LEN_W'(MAX_LEN))
      len_eff = LEN_W'(MAX_LEN);
  end

  // Product at 2*DATA_W bits, then sign- or zero-extended to ACC_W.
  always_comb begin
    prod_s = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
    prod_u = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    if (mode_sel)
      prod_ext = ACC_W'(prod_s);
    else
      prod_ext = ACC_W'(prod_u);
  end

  // Running add with overflow detection in the vector's held mode.
  always_comb begin
    sum_w    = {1'b0, acc_q} + {1'b0, prod_ext};
    s_ovf    = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_w[ACC_W-1] != acc_q[ACC_W-1]);
    u_ovf    = sum_w[ACC_W];
    add_ovf  = mode_q ? s_ovf : u_ovf;
    ovf_next = ovf_q | add_ovf;
`ifdef MAC_STREAM_SAT_EN
    // Once clamped, the accumulator stays at the limit for the rest of the vector.
    if (ovf_q)
      acc_next = acc_q;
    else if (add_ovf) begin
      if (!mode_q)
        acc_next = {ACC_W{1'b1}};
      else if (prod_ext[ACC_W-1])
        acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else
        acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end else
      acc_next = sum_w[ACC_W-1:0];
`else
    acc_next = sum_w[ACC_W-1:0];
`endif
  end

  // Control FSM and datapath registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      run_q       <= 1'b0;
    end else if (ena) begin
      run_q <= 1'b1;
      case (state_q)
        IDLE, HOLD: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
          if (start) begin
            len_q  <= len_eff;
            mode_q <= signed_mode;
            ovf_q  <= 1'b0;
            if (len_eff == LEN_W'(1)) begin
              out_data_q  <= prod_ext;
              out_ovf_q   <= 1'b0;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= HOLD;
            end else begin
              acc_q   <= prod_ext;
              cnt_q   <= LEN_W'(1);
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (in_fire) begin
            if (last_beat) begin
              out_data_q  <= acc_next;
              out_ovf_q   <= ovf_next;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_next;
              ovf_q <= ovf_next;
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: directed bench for mac_stream. Two instances share the
// stimulus: one at ACC_W=32 and one at ACC_W=16, so overflow behaviour is
// reachable. A reference model computes each vector's result with plain
// integer arithmetic; a compare process checks outputs every cycle.
module tb_mac_stream;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        signed_mode;
  logic [4:0]  len;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_ovf32;
  logic [31:0] out_data32;
  logic [1:0]  dbg32;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_data16;
  logic [1:0]  dbg16;

  int errors;
  int checks;

  // exp_q entry: {ovf16, data16[15:0], ovf32, data32[31:0]}
  logic [49:0] exp_q[$];

  bit     m_active;
  bit     m_sgn;
  int     m_left;
  longint m_acc32, m_acc16;
  bit     m_ovf32, m_ovf16;

  mac_stream #(.DATA_W(8), .ACC_W(32), .MAX_LEN(16), .LEN_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .signed_mode(signed_mode), .len(len),
    .in_valid(in_valid), .in_ready(in_ready32), .a(a), .b(b),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .out_ovf(out_ovf32), .dbg_state(dbg32)
  );

  mac_stream #(.DATA_W(8), .ACC_W(16), .MAX_LEN(16), .LEN_W(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .signed_mode(signed_mode), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_ovf(out_ovf16), .dbg_state(dbg16)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint model_prod(input logic [7:0] av, input logic [7:0] bv, input bit sg);
    if (sg)
      return longint'($signed(av)) * longint'($signed(bv));
    else
      return longint'(av) * longint'(bv);
  endfunction

  // Adds p to acc inside the w-bit range of the mode; flags leaving the range.
  task automatic model_add(inout longint acc, inout bit ovf, input longint p,
                           input int w, input bit sg);
    longint span, lo, hi, t;
    span = longint'(1) <<< w;
    lo   = sg ? -(span / 2) : 0;
    hi   = sg ? (span / 2) - 1 : span - 1;
`ifdef MAC_STREAM_SAT_EN
    if (ovf) return;
`endif
    t = acc + p;
    if (t > hi || t < lo) begin
      ovf = 1'b1;
`ifdef MAC_STREAM_SAT_EN
      t = (t > hi) ? hi : lo;
`else
      while (t > hi) t = t - span;
      while (t < lo) t = t + span;
`endif
    end
    acc = t;
  endtask

  task automatic model_beat();
    longint p;
    int     eff;
    if (!m_active) begin
      eff = (len == 5'd0) ? 1 : ((int'(len) > 16) ? 16 : int'(len));
      m_active = 1'b1;
      m_left   = eff;
      m_sgn    = signed_mode;
      p        = model_prod(a, b, m_sgn);
      m_acc32  = p;
      m_acc16  = p;
      m_ovf32  = 1'b0;
      m_ovf16  = 1'b0;
    end else begin
      p = model_prod(a, b, m_sgn);
      model_add(m_acc32, m_ovf32, p, 32, m_sgn);
      model_add(m_acc16, m_ovf16, p, 16, m_sgn);
    end
    m_left--;
    if (m_left == 0) begin
      m_active = 1'b0;
      exp_q.push_back({m_ovf16, m_acc16[15:0], m_ovf32, m_acc32[31:0]});
    end
  endtask

  // Compare process: sample on the falling edge, check, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      exp_q.delete();
      chk("rst_valid32", 64'(out_valid32), 64'd0);
      chk("rst_valid16", 64'(out_valid16), 64'd0);
    end else begin
      if (!ena) begin
        chk("dis_ready32", 64'(in_ready32), 64'd0);
        chk("dis_ready16", 64'(in_ready16), 64'd0);
      end else if (exp_q.size() > 0) begin
        chk("hold_ready32", 64'(in_ready32), 64'(out_ready));
        chk("hold_ready16", 64'(in_ready16), 64'(out_ready));
      end
      chk("valid32", 64'(out_valid32), 64'(exp_q.size() > 0));
      chk("valid16", 64'(out_valid16), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        if (out_valid32) begin
          chk("data32", 64'(out_data32), 64'(exp_q[0][31:0]));
          chk("ovf32",  64'(out_ovf32),  64'(exp_q[0][32]));
        end
        if (out_valid16) begin
          chk("data16", 64'(out_data16), 64'(exp_q[0][48:33]));
          chk("ovf16",  64'(out_ovf16),  64'(exp_q[0][49]));
        end
        if (out_valid32 && out_ready && ena)
          void'(exp_q.pop_front());
      end
      if (in_valid && in_ready32 && ena)
        model_beat();
    end
  end

  // Driver: present one beat and hold it until it is accepted.
  task automatic send(input logic [7:0] av, input logic [7:0] bv,
                      input logic [4:0] lv, input logic sg);
    int n;
    a = av; b = bv; len = lv; signed_mode = sg; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready32 && ena) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [15:0] exp_u16;
  logic [15:0] exp_s16;

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; len = '0; signed_mode = 1'b0;
`ifdef MAC_STREAM_SAT_EN
    exp_u16 = 16'hFFFF;
    exp_s16 = 16'h7FFF;
`else
    exp_u16 = 16'hFC02;
    exp_s16 = 16'h8000;
`endif

    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("reset_data32",  64'(out_data32), 64'd0);
    chk("reset_ovf32",   64'(out_ovf32),  64'd0);
    chk("reset_ready32", 64'(in_ready32), 64'd0);
    chk("reset_data16",  64'(out_data16), 64'd0);
    rst_n = 1'b1; ena = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Unsigned len=4: 15+14+100+1 = 130, visible right after the 4th beat
    send(8'd3, 8'd5, 5'd4, 1'b0);
    send(8'd2, 8'd7, 5'd4, 1'b0);
    send(8'd10, 8'd10, 5'd4, 1'b0);
    chk("u4_early_valid", 64'(out_valid32), 64'd0);
    send(8'd1, 8'd1, 5'd4, 1'b0);
    chk("u4_valid", 64'(out_valid32), 64'd1);
    chk("u4_data",  64'(out_data32),  64'd130);
    chk("u4_ovf",   64'(out_ovf32),   64'd0);
    @(posedge clk); #1;
    chk("u4_pulse_end", 64'(out_valid32), 64'd0);

    // Signed len=3: -10 - 12 - 16256 = -16278
    send(8'hFE, 8'd5, 5'd3, 1'b1);
    send(8'd4, 8'hFD, 5'd3, 1'b1);
    send(8'h7F, 8'h80, 5'd3, 1'b1);
    chk("s3_data32", 64'(out_data32), 64'hFFFFC06A);
    chk("s3_data16", 64'(out_data16), 64'hC06A);
    chk("s3_ovf32",  64'(out_ovf32),  64'd0);
    @(posedge clk); #1;

    // Backpressure: 42+72=114 held for 5 cycles, then accepted together with a new beat
    out_ready = 1'b0;
    send(8'd6, 8'd7, 5'd2, 1'b0);
    send(8'd8, 8'd9, 5'd2, 1'b0);
    a = 8'd5; b = 8'd6; len = 5'd1; signed_mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid32), 64'd1);
      chk("bp_data",  64'(out_data32),  64'd114);
      chk("bp_ready", 64'(in_ready32),  64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_join_ready", 64'(in_ready32), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 64'(out_valid32), 64'd1);
    chk("bp_next_data",  64'(out_data32),  64'd30);
    @(posedge clk); #1;

    // len=0 acts as one beat; result held while ena is low
    send(8'd9, 8'd9, 5'd0, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("len0_hold_valid", 64'(out_valid32), 64'd1);
      chk("len0_hold_data",  64'(out_data32),  64'd81);
    end
    @(posedge clk); #1;
    ena = 1'b1;
    @(posedge clk); #1;

    // len=31 clamps to 16 beats: 2*(1+..+16) = 272
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) chk("len31_not_early", 64'(out_valid32), 64'd0);
      send(8'(i), 8'd2, 5'd31, 1'b0);
    end
    chk("len31_valid", 64'(out_valid32), 64'd1);
    chk("len31_data",  64'(out_data32),  64'd272);
    @(posedge clk); #1;

    // len changes mid-vector are ignored: 1+4+9 = 14
    send(8'd1, 8'd1, 5'd3, 1'b0);
    send(8'd2, 8'd2, 5'd1, 1'b0);
    chk("lenchg_not_early", 64'(out_valid32), 64'd0);
    send(8'd3, 8'd3, 5'd31, 1'b0);
    chk("lenchg_data", 64'(out_data32), 64'd14);
    @(posedge clk); #1;

    // Unsigned overflow at ACC_W=16: 65025+65025
    send(8'd255, 8'd255, 5'd2, 1'b0);
    send(8'd255, 8'd255, 5'd2, 1'b0);
    chk("uovf_ovf16",  64'(out_ovf16),  64'd1);
    chk("uovf_data16", 64'(out_data16), 64'(exp_u16));
    chk("uovf_ovf32",  64'(out_ovf32),  64'd0);
    chk("uovf_data32", 64'(out_data32), 64'h1FC02);
    @(posedge clk); #1;

    // Signed overflow at ACC_W=16: 16384+16384+0
    send(8'h80, 8'h80, 5'd3, 1'b1);
    send(8'h80, 8'h80, 5'd3, 1'b1);
    send(8'd0, 8'd0, 5'd3, 1'b1);
    chk("sovf_ovf16",  64'(out_ovf16),  64'd1);
    chk("sovf_data16", 64'(out_data16), 64'(exp_s16));
    chk("sovf_data32", 64'(out_data32), 64'h8000);
    @(posedge clk); #1;

    // Overflow flag cleared by the next vector
    send(8'd2, 8'd2, 5'd1, 1'b0);
    chk("ovf_clear16", 64'(out_ovf16), 64'd0);
    @(posedge clk); #1;

    // ena low mid-vector, then reset mid-vector discards the partial sum
    send(8'd2, 8'd3, 5'd3, 1'b0);
    ena = 1'b0;
    a = 8'd4; b = 8'd5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ena_ready", 64'(in_ready32), 64'd0);
      chk("ena_valid", 64'(out_valid32), 64'd0);
    end
    @(posedge clk); #1;
    ena = 1'b1;
    send(8'd4, 8'd5, 5'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid32), 64'd0);
    chk("midrst_data",  64'(out_data32),  64'd0);
    chk("midrst_ready", 64'(in_ready32),  64'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'd7, 8'd8, 5'd1, 1'b0);
    chk("post_rst_valid", 64'(out_valid32), 64'd1);
    chk("post_rst_data",  64'(out_data32),  64'd56);

    repeat (3) @(posedge clk); #1;
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
